// File: rtl/cdb_arbiter_pkg.sv
// ============================================================================
// Module : cdb_arbiter_pkg
// Brief  : Shared CDB packet type and sizing constants for the CDB arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package cdb_arbiter_pkg;

    localparam int NUM_FU_DEFAULT = 4;
    localparam int TAG_W          = 6;
    localparam int DATA_W         = 32;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_packet_s;

endpackage

`default_nettype wire

// File: rtl/cdb_arbiter_picker.sv
// ============================================================================
// Module : rr_priority_picker
// Brief  : Combinational round-robin search: first request at or after i_ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_priority_picker #(
    parameter int NUM_FU = 4,
    parameter int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic [NUM_FU-1:0] i_req,
    input  logic [PTR_W-1:0]  i_ptr,
    output logic [NUM_FU-1:0] o_grant,
    output logic [PTR_W-1:0]  o_idx,
    output logic              o_found
);

    logic [PTR_W-1:0] w_cand;

    // Scan offsets from farthest to nearest so the nearest request wins last.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_found = 1'b0;
        w_cand  = '0;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            w_cand = PTR_W'((int'(i_ptr) + i) % NUM_FU);
            if (i_req[w_cand]) begin
                o_found = 1'b1;
                o_idx   = w_cand;
            end
        end
        if (o_found) begin
            o_grant[o_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module : cdb_arbiter
// Brief  : Round-robin common-data-bus arbiter with registered broadcast.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = NUM_FU_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  cdb_packet_s [NUM_FU-1:0] fu_result_i,
    input  logic                     flush_i,
    output logic [NUM_FU-1:0]        grant_o,
    output cdb_packet_s              cdb_o,
    output logic [31:0]              bcast_count_o
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [PTR_W-1:0]  r_rr_ptr;
    cdb_packet_s       r_cdb;
    logic [31:0]       r_bcast_count;

    logic [NUM_FU-1:0] w_req;
    logic [NUM_FU-1:0] w_pick_grant;
    logic [PTR_W-1:0]  w_win_idx;
    logic              w_found;
    logic              w_grant_any;

    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_req[i] = fu_result_i[i].valid;
        end
    end

    rr_priority_picker #(
        .NUM_FU (NUM_FU),
        .PTR_W  (PTR_W)
    ) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_win_idx),
        .o_found (w_found)
    );

    // Reset masks the grant combinationally so it is zero regardless of the clock.
    assign w_grant_any = w_found & ~flush_i & ~reset_i;
    assign grant_o     = w_grant_any ? w_pick_grant : '0;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rr_ptr      <= '0;
            r_cdb         <= '0;
            r_bcast_count <= '0;
        end else if (w_grant_any) begin
            r_rr_ptr      <= (w_win_idx == PTR_W'(NUM_FU - 1)) ? '0 : w_win_idx + 1'b1;
            r_cdb         <= fu_result_i[w_win_idx];
            r_cdb.valid   <= 1'b1;
            r_bcast_count <= r_bcast_count + 32'd1;
        end else begin
            r_cdb         <= '0;
        end
    end

    assign cdb_o         = r_cdb;
    assign bcast_count_o = r_bcast_count;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module : tb_cdb_arbiter
// Brief  : Directed self-checking bench for cdb_arbiter (NUM_FU = 4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic              clk_i;
    logic              reset_i;
    cdb_packet_s [3:0] fu_result_i;
    logic              flush_i;
    logic [3:0]        grant_o;
    cdb_packet_s       cdb_o;
    logic [31:0]       bcast_count_o;

    int checks;
    int errors;

    cdb_arbiter #(.NUM_FU(4)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .fu_result_i   (fu_result_i),
        .flush_i       (flush_i),
        .grant_o       (grant_o),
        .cdb_o         (cdb_o),
        .bcast_count_o (bcast_count_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Each FU carries a recognisable packet: tag 8+i, data 0xA000_0000+i.
    task automatic drive(input logic [3:0] mask, input logic fl);
        for (int i = 0; i < 4; i++) begin
            fu_result_i[i].valid = mask[i];
            fu_result_i[i].tag   = TAG_W'(8 + i);
            fu_result_i[i].data  = 32'hA000_0000 + 32'(i);
        end
        flush_i = fl;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_i = 1'b1;
        drive(4'b0001, 1'b0);

        // Reset state, with a request present
        #3;
        chk("rst_grant", 64'(grant_o), 64'h0);
        chk("rst_cdb",   64'(cdb_o), 64'h0);
        chk("rst_count", 64'(bcast_count_o), 64'h0);

        // Single request from FU2 after reset
        @(negedge clk_i);
        reset_i = 1'b0;
        drive(4'b0000, 1'b0);
        fu_result_i[2].valid = 1'b1;
        fu_result_i[2].data  = 32'h1234_5678;
        fu_result_i[2].tag   = TAG_W'(5);
        #1;
        chk("single_grant", 64'(grant_o), 64'h4);
        @(negedge clk_i);
        drive(4'b0000, 1'b0);
        chk("single_valid", 64'(cdb_o.valid), 64'h1);
        chk("single_data",  64'(cdb_o.data), 64'h1234_5678);
        chk("single_tag",   64'(cdb_o.tag), 64'h5);
        chk("single_count", 64'(bcast_count_o), 64'h1);

        // Asynchronous reset between edges while a broadcast is visible
        reset_i = 1'b1;
        #1;
        chk("async_valid", 64'(cdb_o.valid), 64'h0);
        chk("async_count", 64'(bcast_count_o), 64'h0);
        @(negedge clk_i);
        reset_i = 1'b0;

        // All four requesting continuously from reset
        drive(4'b1111, 1'b0);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr_grant_%0d", k), 64'(grant_o), 64'(4'b0001 << (k % 4)));
            @(negedge clk_i);
        end
        drive(4'b0000, 1'b0);
        chk("rr_last_tag", 64'(cdb_o.tag), 64'd11);
        chk("rr_count",    64'(bcast_count_o), 64'd8);

        // Pointer skip: grant FU2 moves pointer to 3, then only FU1 requests
        @(negedge clk_i);
        drive(4'b0100, 1'b0);
        #1;
        chk("skip_pre_grant", 64'(grant_o), 64'h4);
        @(negedge clk_i);
        drive(4'b0010, 1'b0);
        #1;
        chk("skip_grant", 64'(grant_o), 64'h2);
        @(negedge clk_i);
        drive(4'b1111, 1'b0);
        #1;
        chk("skip_ptr_is_2", 64'(grant_o), 64'h4);
        @(negedge clk_i);
        chk("skip_count", 64'(bcast_count_o), 64'd11);

        // Flush with FU1 and FU3 pending: pointer stays at 3
        drive(4'b1010, 1'b1);
        #1;
        chk("flush_grant", 64'(grant_o), 64'h0);
        @(negedge clk_i);
        chk("flush_cdb",   64'(cdb_o), 64'h0);
        chk("flush_count", 64'(bcast_count_o), 64'd11);
        drive(4'b1111, 1'b0);
        #1;
        chk("flush_ptr_kept", 64'(grant_o), 64'h8);
        @(negedge clk_i);
        chk("post_flush_tag",   64'(cdb_o.tag), 64'd11);
        chk("post_flush_count", 64'(bcast_count_o), 64'd12);

        // Counter wrap, followed by FU0 holding valid for a second cycle
        drive(4'b0001, 1'b0);
        dut.r_bcast_count = 32'hFFFF_FFFF;
        #1;
        chk("wrap_grant", 64'(grant_o), 64'h1);
        @(negedge clk_i);
        chk("wrap_count", 64'(bcast_count_o), 64'h0);
        chk("wrap_tag",   64'(cdb_o.tag), 64'd8);
        #1;
        chk("hold_grant", 64'(grant_o), 64'h1);
        @(negedge clk_i);
        drive(4'b0000, 1'b0);
        chk("hold_count", 64'(bcast_count_o), 64'h1);
        @(negedge clk_i);
        chk("idle_cdb",   64'(cdb_o), 64'h0);
        chk("idle_count", 64'(bcast_count_o), 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional units requesting the common data bus.
REQ-002 Port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset_i, input, 1: reset, asynchronous and active-high.
REQ-004 Port fu_result_i, input, NUM_FU x cdb_packet_s: per-FU result packet; .valid is that FU's bus request.
REQ-005 Port flush_i, input, 1: pipeline flush; suppresses grants and broadcast.
REQ-006 Port grant_o, input-dependent output, NUM_FU: per-FU grant, one-hot or zero.
REQ-007 Port cdb_o, output, cdb_packet_s: registered CDB broadcast to reservation stations and ROB.
REQ-008 Port bcast_count_o, output, 32: count of packets broadcast since reset.

Function
REQ-009 The block SHALL compute grant_o combinationally in the same cycle as the requests.
  - A requesting FU sees its grant in the cycle it presents valid.
REQ-010 The block SHALL assert at most one grant_o bit per cycle.
REQ-011 The block SHALL assert grant_o[i] only when fu_result_i[i].valid=1 and flush_i=0.
REQ-012 Arbitration SHALL be round-robin from pointer rr_ptr (0..NUM_FU-1).
  - Winner is the first valid index scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_FU.
REQ-013 On a grant to index w, rr_ptr SHALL become (w+1) mod NUM_FU at the next edge; with no grant it SHALL hold.
REQ-014 With at least one valid request and flush_i=0, the block SHALL issue a grant; it SHALL never idle the bus while requests are pending.
REQ-015 On a grant to w, the next edge SHALL load cdb_o from fu_result_i[w] with cdb_o.valid=1.
  - Broadcast latency is exactly 1 cycle after grant.
REQ-016 In a cycle with no grant, the next edge SHALL set every cdb_o field to zero.
REQ-017 bcast_count_o SHALL increment by 1 at each edge that follows a grant, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-018 flush_i=1 SHALL have the following effects:
  - zero grants that cycle;
  - cdb_o all-zero next cycle;
  - rr_ptr and bcast_count_o unchanged.
REQ-019 The block SHALL tolerate a granted FU holding valid for extra cycles; each held cycle is a fresh request.
  - Normal FUs drop valid the cycle after grant.
REQ-020 Under continuous requests from all NUM_FU units, each FU SHALL be granted exactly once in every NUM_FU consecutive grant cycles (no starvation).
REQ-021 Requests with a packet field other than .valid set are not checked; the block SHALL forward packet contents unmodified.

Reset
REQ-022 While reset_i=1, the block SHALL hold the following values regardless of the clock:
  - rr_ptr=0;
  - cdb_o all-zero;
  - bcast_count_o=0;
  - grant_o all-zero.
REQ-023 Reset asserted mid-broadcast SHALL immediately clear cdb_o.valid; the packet is dropped.
  - Recovery is the owning FU's responsibility via flush.
REQ-024 In the first edge after reset deassertion, the block SHALL arbitrate normally starting from index 0.

Structure
REQ-025 cdb_packet_s and the constant NUM_FU_DEFAULT SHALL reside in the shared structs package, not locally.
REQ-026 The round-robin search SHALL be a sub-module rr_priority_picker.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and encoded winner index.
  - Purely combinational.
REQ-027 The arbiter SHALL own rr_ptr, the cdb_o register and the broadcast counter; there are no other state elements.

Verification
REQ-028 Reset then a single request:
  - Stimulus: reset; then only FU2 valid with data=0x12345678, tag=5.
  - Response: grant_o=0100 that cycle; next cycle cdb_o.valid=1, data=0x12345678, tag=5; bcast_count_o=1.
REQ-029 All four requesting continuously for 8 cycles from reset:
  - grant_o sequence is 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000.
REQ-030 Flush with requests pending:
  - Stimulus: FU1 and FU3 valid with flush_i=1.
  - Response: grant_o=0000; next cycle cdb_o.valid=0, rr_ptr unchanged, bcast_count_o unchanged.
REQ-031 Pointer skip:
  - Stimulus: rr_ptr=3 with only FU1 valid.
  - Response: grant_o=0010; rr_ptr=2 afterwards.
REQ-032 Asynchronous reset mid-operation:
  - Stimulus: assert reset_i between edges while cdb_o.valid=1.
  - Response: cdb_o.valid=0 and bcast_count_o=0 before the next edge.
REQ-033 Counter wrap: preload bcast_count_o to 0xFFFFFFFF, issue one grant -> next cycle bcast_count_o=0.
